calc_op_sequencer: RTL

Multi-cycle operation sequencer for the calculator datapath. It captures two 16-bit operands and a 3-bit opcode on a start pulse from the stage selector, then runs the selected operation: add, subtract, shift-add multiply or restoring divide. Its 32-bit answer drives the seven-segment display and LED visualizer, so the top level shares one sequenced arithmetic path instead of instantiating a separate combinational unit per operation.

---
 rtl/calc_op_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: multi-cycle add / sub / shift-add multiply / restoring
// divide sequencer with one shared (W+1)-bit adder/subtractor.
// Optional divider: define CALC_SEQ_DIV_EN to build the divide path; without
// it opcode 011 is reported as illegal and div_by_zero is tied low.
module calc_op_sequencer #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     opcode,
  input  logic [W-1:0]   num1,
  input  logic [W-1:0]   num2,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] answer,
  output logic           div_by_zero,
  output logic           illegal_op
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
`ifdef CALC_SEQ_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b011;
`endif

  typedef enum logic [1:0] {IDLE, CALC, ITER, FINISH} state_t;

  state_t           state_reg, state_next;
  logic             armed_reg, armed_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [2:0]       op_reg, op_next;
  logic [2*W-1:0]   acc_reg, acc_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [2*W-1:0]   answer_reg, answer_next;
  logic             ill_pend_reg, ill_pend_next;
  logic             ill_reg, ill_next;
`ifdef CALC_SEQ_DIV_EN
  logic             dz_pend_reg, dz_pend_next;
  logic             dz_reg, dz_next;
`endif

  // The single shared adder/subtractor; bit W is the sign/carry.
  logic [W:0] alu_a, alu_b, alu_res;
  logic       alu_sub;

  assign alu_res = alu_a + (alu_sub ? ~alu_b : alu_b) + {{W{1'b0}}, alu_sub};

  // Route operands into the shared adder depending on what the FSM is doing.
  always_comb begin
    alu_a   = {1'b0, a_reg};
    alu_b   = {1'b0, b_reg};
    alu_sub = (op_reg == OP_SUB);
    if (state_reg == ITER) begin
`ifdef CALC_SEQ_DIV_EN
      if (op_reg == OP_DIV) begin
        // Partial remainder shifted left with the next dividend bit, minus divisor.
        alu_a   = {acc_reg[2*W-1:W], acc_reg[W-1]};
        alu_b   = {1'b0, b_reg};
        alu_sub = 1'b1;
      end else
`endif
      begin
        // Upper product half plus multiplicand.
        alu_a   = {1'b0, acc_reg[2*W-1:W]};
        alu_b   = {1'b0, a_reg};
        alu_sub = 1'b0;
      end
    end
  end

  // Next-state and datapath control for the sequencer FSM.
  always_comb begin
    state_next    = state_reg;
    armed_next    = 1'b1;
    a_next        = a_reg;
    b_next        = b_reg;
    op_next       = op_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    answer_next   = answer_reg;
    ill_pend_next = ill_pend_reg;
    ill_next      = ill_reg;
`ifdef CALC_SEQ_DIV_EN
    dz_pend_next  = dz_pend_reg;
    dz_next       = dz_reg;
`endif

    case (state_reg)
      IDLE: begin
        // armed_reg blocks a start seen on the first edge after reset release.
        if (start && armed_reg) begin
          a_next     = num1;
          b_next     = num2;
          op_next    = opcode;
          ill_next   = 1'b0;
`ifdef CALC_SEQ_DIV_EN
          dz_next    = 1'b0;
`endif
          busy_next  = 1'b1;
          state_next = CALC;
        end
      end

      CALC: begin
        count_next    = '0;
        ill_pend_next = 1'b0;
`ifdef CALC_SEQ_DIV_EN
        dz_pend_next  = 1'b0;
`endif
        case (op_reg)
          OP_ADD: begin
            acc_next   = {{(W-1){1'b0}}, alu_res};
            state_next = FINISH;
          end
          OP_SUB: begin
            acc_next   = {{(W-1){alu_res[W]}}, alu_res};
            state_next = FINISH;
          end
          OP_MUL: begin
            // Multiplier sits in the low half and is consumed LSB first.
            acc_next   = {{W{1'b0}}, b_reg};
            state_next = ITER;
          end
`ifdef CALC_SEQ_DIV_EN
          OP_DIV: begin
            if (b_reg == '0) begin
              acc_next     = {a_reg, {W{1'b1}}};
              dz_pend_next = 1'b1;
              state_next   = FINISH;
            end else begin
              // Dividend in the low half becomes the quotient as it shifts out.
              acc_next   = {{W{1'b0}}, a_reg};
              state_next = ITER;
            end
          end
`endif
          default: begin
            acc_next      = '0;
            ill_pend_next = 1'b1;
            state_next    = FINISH;
          end
        endcase
      end

      ITER: begin
`ifdef CALC_SEQ_DIV_EN
        if (op_reg == OP_DIV) begin
          // Negative trial difference means restore: just shift in a 0 bit.
          if (alu_res[W])
            acc_next = {acc_reg[2*W-2:0], 1'b0};
          else
            acc_next = {alu_res[W-1:0], acc_reg[W-2:0], 1'b1};
        end else
`endif
        begin
          if (acc_reg[0])
            acc_next = {alu_res, acc_reg[W-1:1]};
          else
            acc_next = {1'b0, acc_reg[2*W-1:1]};
        end
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(W - 1))
          state_next = FINISH;
      end

      FINISH: begin
        answer_next = acc_reg;
        done_next   = 1'b1;
        busy_next   = 1'b0;
        ill_next    = ill_pend_reg;
`ifdef CALC_SEQ_DIV_EN
        dz_next     = dz_pend_reg;
`endif
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      armed_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      acc_reg      <= '0;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      answer_reg   <= '0;
      ill_pend_reg <= 1'b0;
      ill_reg      <= 1'b0;
`ifdef CALC_SEQ_DIV_EN
      dz_pend_reg  <= 1'b0;
      dz_reg       <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      armed_reg    <= armed_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      op_reg       <= op_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      answer_reg   <= answer_next;
      ill_pend_reg <= ill_pend_next;
      ill_reg      <= ill_next;
`ifdef CALC_SEQ_DIV_EN
      dz_pend_reg  <= dz_pend_next;
      dz_reg       <= dz_next;
`endif
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign answer     = answer_reg;
  assign illegal_op = ill_reg;
`ifdef CALC_SEQ_DIV_EN
  assign div_by_zero = dz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
